sevseg_capture: RTL and testbench
=================================

// Module: sevseg_capture
// PURPOSE
//  Receive-side counterpart of the BCD->7-segment encoder: monitors the multiplexed segment/digit-enable
//  lines of a scanned display and turns each stable segment pattern back into a BCD digit.
//  A frame is complete once every digit position has been captured.
//  The frame is then presented on a valid/ready interface.
//  Sits between the display scan driver (or display pins in loopback) and a checker/host register.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digit positions (1..8)
//  STABLE_CYCLES  3  consecutive identical samples required before a digit is captured (>=1)
//  SEG_ACT_LOW    0  1: seg and dig_en are active-low at the pins; inverted at the input register
// PORTS
//  clk          in   1             single clock; all logic rising-edge
//  rst_n        in   1             asynchronous active-low reset
//  dig_en       in   NUM_DIGITS    digit enable from the scanner, one-hot when a digit is lit
//  seg          in   7             segment lines, seg[0]=a ... seg[6]=g
//  frame_bcd    out  4*NUM_DIGITS  captured frame; digit i at [4i+3:4i]
//  frame_err    out  1             frame contains at least one undecodable pattern
//  frame_valid  out  1             frame_bcd/frame_err valid, held until accepted
//  frame_ready  in   1             consumer accepts when frame_valid & frame_ready
//  overrun      out  1             1-cycle pulse: a completed frame was dropped
//  onehot_err   out  1             1-cycle pulse: dig_en changed to a multi-hot value
// BEHAVIOUR
//  Reset:
//   - all outputs 0; frame_bcd=0; seen mask, stability counter, sample register and capture buffer cleared.
//  Input stage:
//   - seg/dig_en registered once (1-cycle latency).
//   - Normalised to active-high when SEG_ACT_LOW=1.
//  Stability counter:
//   - Counts edges on which the registered {dig_en,seg} equals the previous registered value.
//   - Clears to 0 on any change; saturates at STABLE_CYCLES.
//  Capture:
//   - Occurs on the edge where the counter reaches STABLE_CYCLES-1 and dig_en is one-hot.
//   - Exactly once per dwell; re-armed only by a change of {dig_en,seg}.
//   - Decode: 3F->0 06->1 5B->2 4F->3 66->4 6D->5 7D->6 07->7 7F->8 6F->9.
//   - Any other pattern (including 00) writes 4'hF, sets the buffer error flag, and still marks the digit seen.
//   - A re-captured digit overwrites its slot in the buffer.
//  dig_en==0:
//   - Blanking interval; no capture, counter held at 0.
//  dig_en multi-hot:
//   - No capture; onehot_err pulses on the first cycle of that value only.
//  Frame completion:
//   - Triggered by the capture edge that makes the seen mask all ones.
//   - If frame_valid=0, or frame_valid&frame_ready on that same edge:
//     - buffer and error flag copy to frame_bcd/frame_err;
//     - frame_valid=1 on that edge (one cycle after the last digit's capture condition became true);
//     - seen mask and buffer error flag clear.
//   - Else (pending frame not accepted):
//     - new frame dropped, old frame held unchanged;
//     - overrun pulses; seen mask and error flag clear.
//  Handshake:
//   - frame_valid falls on the edge after acceptance unless a new frame completes on that same edge.
//   - frame_bcd is stable while frame_valid=1 and not accepted.
//  Reset mid-frame:
//   - Partial buffer discarded; the next frame starts from an empty seen mask.
//  FSM (2 states):
//   - EMPTY: frame_valid=0; go to FULL on frame completion.
//   - FULL: frame_valid=1; go to EMPTY on accept without simultaneous completion, otherwise stay FULL.
// STRUCTURE
//  Shared package sevseg_pkg:
//   - segment constants SEG_0..SEG_9, SEG_BLANK=7'h00;
//   - BCD_INVALID=4'hF; segment-index constants A..G.
//   - The encoder uses the same constants.
//  Sub-module sevseg_decode:
//   - combinational 7-bit pattern -> {valid, bcd[3:0]}; reused by bench scoreboards.
//  Top holds the input register, stability counter, seen mask/buffer and output FSM.
// TESTING
//  1. Reset, NUM_DIGITS=4, scan digits 0..3 with 3F,06,5B,4F, 8 cycles each
//     -> frame_bcd=16'h3210, frame_err=0, frame_valid=1 one cycle after digit 3 capture.
//  2. Dwell of 2 cycles (<STABLE_CYCLES) on digit 2, then a 3-cycle dwell
//     -> only the 3-cycle dwell is captured; a 2-cycle dwell alone leaves the frame incomplete.
//  3. Digit 1 shows 7'h49 -> frame_bcd[7:4]=4'hF, frame_err=1, frame still completes.
//  4. Hold frame_ready=0 through two full scans -> first frame held, overrun pulses once;
//     then frame_ready=1 -> valid drops the next cycle.
//  5. dig_en=4'b0110 for 5 cycles -> onehot_err single pulse, no capture;
//     dig_en=0 blanking gaps between digits -> no effect on capture.
//  6. Assert rst_n=0 after 2 of 4 digits; release; scan a full 6,7,8,9 frame
//     -> frame_bcd=16'h9876, no stale digits.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared seven-segment constants and capture FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Segment bit order is seg[0]=a ... seg[6]=g, active-high. The encoder uses
// the same patterns, so both ends of a loopback agree by construction.
package sevseg_pkg;

  // Segment bit positions within a 7-bit pattern.
  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;
  localparam int D = 3;
  localparam int E = 4;
  localparam int F = 5;
  localparam int G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Output side of the capture block: EMPTY has no frame pending,
  // FULL holds a frame until the consumer accepts it.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sevseg_capture_if.sv
// Frame output bus of the segment capture block (valid/ready).
// Latency: n/a (wiring only).
// Backpressure: producer holds frame_bcd/frame_err/frame_valid until frame_ready.
//
// Ports:
//   frame_bcd   captured frame, digit i at [4i+3:4i]
//   frame_err   frame contains at least one undecodable pattern
//   frame_valid frame_bcd/frame_err valid
//   frame_ready consumer accepts when frame_valid & frame_ready
interface sevseg_capture_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic                    frame_err;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (
    output frame_bcd,
    output frame_err,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_bcd,
    input  frame_err,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/sevseg_decode.sv
// Seven-segment pattern to BCD decoder (inverse of the encoder table).
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   seg_i    7-bit active-high pattern, seg_i[0]=a ... seg_i[6]=g
//   valid_o  1 when seg_i is one of the ten digit patterns
//   bcd_o    decoded digit, BCD_INVALID when valid_o=0
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    valid_o = 1'b1;
    bcd_o   = BCD_INVALID;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      // Blank and every partial/garbled pattern land here.
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevseg_capture.sv
// Captures stable digit patterns from a scanned 7-segment display into BCD frames.
// Latency: 1 input register + STABLE_CYCLES dwell; frame_valid rises on the last digit's capture edge.
// Backpressure: frame held until accepted; a frame completing while one is pending is dropped (overrun).
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   dig_en       digit enables from the scanner, one-hot while a digit is lit
//   seg          segment lines, seg[0]=a ... seg[6]=g
//   frm          frame output bus (valid/ready), see sevseg_capture_if
//   overrun      1-cycle pulse: a completed frame was dropped
//   onehot_err   1-cycle pulse: dig_en changed to a multi-hot value
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  parameter bit SEG_ACT_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] dig_en,
  input  logic [6:0]            seg,
  sevseg_capture_if.master      frm,
  output logic                  overrun,
  output logic                  onehot_err
);

  // Counter is wide enough to hold its saturation value STABLE_CYCLES.
  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_CAP = CW'(STABLE_CYCLES - 1);

  // Input stage (normalised to active-high) and its one-cycle-old copy.
  logic [NUM_DIGITS-1:0]   dig_n, dig_q, dig_prev_q;
  logic [6:0]              seg_n, seg_q, seg_prev_q;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_nx;
  logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
  logic                    err_q, err_d, err_nx;

  logic                    same_w, onehot_w, multihot_w, capture_w;
  logic                    complete_w, accept_w, load_w, drop_w;
  logic                    dec_vld;
  logic [3:0]              dec_bcd;

  cap_state_e              state_q;
  logic                    frame_valid_q, frame_err_q;
  logic [4*NUM_DIGITS-1:0] frame_bcd_q;
  logic                    overrun_q, onehot_err_q;

  always_comb begin
    dig_n = SEG_ACT_LOW ? ~dig_en : dig_en;
    seg_n = SEG_ACT_LOW ? ~seg    : seg;
  end

  assign same_w     = (dig_q == dig_prev_q) && (seg_q == seg_prev_q);
  assign onehot_w   = $onehot(dig_q);
  assign multihot_w = !$onehot0(dig_q);

  sevseg_decode u_decode (
    .seg_i   (seg_q),
    .valid_o (dec_vld),
    .bcd_o   (dec_bcd)
  );

  // Stability counter: held at 0 while blanked, restarts on any change,
  // saturates so the capture value CNT_CAP is crossed once per dwell.
  always_comb begin
    cnt_d = cnt_q;
    if ((dig_q == '0) || !same_w) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Capture fires on the edge where the counter lands on CNT_CAP. With
  // STABLE_CYCLES=1 that is the first sample after a change.
  assign capture_w = onehot_w && (cnt_d == CNT_CAP);

  // Buffer/seen/error as they would be after this edge's capture, so the
  // completing digit is already included when the frame is copied out.
  always_comb begin
    buf_d   = buf_q;
    seen_nx = seen_q;
    err_nx  = err_q;
    if (capture_w) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_q[i]) begin
          buf_d[4*i +: 4] = dec_bcd;
        end
      end
      seen_nx = seen_q | dig_q;
      err_nx  = err_q | !dec_vld;
    end
  end

  assign complete_w = capture_w && (&seen_nx);
  assign accept_w   = frame_valid_q && frm.frame_ready;
  assign load_w     = complete_w && (!frame_valid_q || accept_w);
  assign drop_w     = complete_w && !load_w;

  // A completed frame always restarts collection, whether delivered or dropped.
  assign seen_d = complete_w ? '0   : seen_nx;
  assign err_d  = complete_w ? 1'b0 : err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q        <= '0;
      seg_q        <= '0;
      dig_prev_q   <= '0;
      seg_prev_q   <= '0;
      cnt_q        <= '0;
      seen_q       <= '0;
      buf_q        <= '0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      dig_q        <= dig_n;
      seg_q        <= seg_n;
      dig_prev_q   <= dig_q;
      seg_prev_q   <= seg_q;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      buf_q        <= buf_d;
      err_q        <= err_d;
      overrun_q    <= drop_w;
      // Only the first cycle of a new multi-hot value is flagged.
      onehot_err_q <= multihot_w && (dig_q != dig_prev_q);
    end
  end

  // Output FSM with registered frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      frame_valid_q <= 1'b0;
      frame_bcd_q   <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load_w) begin
            state_q       <= ST_FULL;
            frame_valid_q <= 1'b1;
            frame_bcd_q   <= buf_d;
            frame_err_q   <= err_nx;
          end
        end
        ST_FULL: begin
          if (load_w) begin
            // Accept and completion on the same edge: hand over back to back.
            frame_bcd_q <= buf_d;
            frame_err_q <= err_nx;
          end else if (accept_w) begin
            state_q       <= ST_EMPTY;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_EMPTY;
          frame_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign frm.frame_bcd   = frame_bcd_q;
  assign frm.frame_err   = frame_err_q;
  assign frm.frame_valid = frame_valid_q;
  assign overrun         = overrun_q;
  assign onehot_err      = onehot_err_q;

endmodule

// File: tb/tb_sevseg_capture.sv
// Self-checking bench for sevseg_capture (NUM_DIGITS=4, STABLE_CYCLES=3, active-high pins).
// Expected frames are queued as digits are scanned and compared when frame_valid appears.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_sevseg_capture;

  typedef struct packed {
    logic [15:0] bcd;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig_en;
  logic [6:0] seg;
  logic       overrun;
  logic       onehot_err;

  int   checks   = 0;
  int   failures = 0;
  int   ov_cnt   = 0;
  int   oh_cnt   = 0;
  exp_t exp_q[$];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  sevseg_capture_if #(.NUM_DIGITS(4)) frm ();

  sevseg_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (3),
    .SEG_ACT_LOW   (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dig_en     (dig_en),
    .seg        (seg),
    .frm        (frm),
    .overrun    (overrun),
    .onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  // Drive dig_en/seg for n cycles, tallying the pulse outputs each cycle.
  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_en = d;
    seg    = s;
    repeat (n) begin
      @(posedge clk);
      #1;
      ov_cnt += int'(overrun);
      oh_cnt += int'(onehot_err);
    end
  endtask

  task automatic show(input int pos, input int val, input int n);
    hold(4'(1 << pos), seg_tab[val], n);
  endtask

  task automatic scan(input int v0, input int v1, input int v2, input int v3);
    show(0, v0, 8);
    show(1, v1, 8);
    show(2, v2, 8);
    show(3, v3, 8);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (frm.frame_valid === 1'b1) ok = 1'b1;
      else hold(dig_en, seg, 1);
    end
  endtask

  task automatic accept();
    frm.frame_ready = 1'b1;
    hold(dig_en, seg, 1);
    frm.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    dig_en          = '0;
    seg             = '0;
    frm.frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", frm.frame_valid);
    end
    checks++;
    if (frm.frame_bcd !== 16'h0000) begin
      failures++; $display("FAIL reset_bcd got=%h exp=0000", frm.frame_bcd);
    end
    checks++;
    if ({frm.frame_err, overrun, onehot_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {frm.frame_err, overrun, onehot_err});
    end
    rst_n = 1'b1;
    hold(4'b0000, 7'h00, 2);
  endtask

  task automatic test_basic();
    exp_t e;
    exp_q.push_back({16'h3210, 1'b0});
    show(0, 0, 8);
    show(1, 1, 8);
    show(2, 2, 8);
    show(3, 3, 3);
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL basic_valid_early got=%b exp=0", frm.frame_valid);
    end
    hold(dig_en, seg, 1);
    checks++;
    if (frm.frame_valid !== 1'b1) begin
      failures++; $display("FAIL basic_valid_edge got=%b exp=1", frm.frame_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (frm.frame_bcd !== e.bcd) begin
        failures++; $display("FAIL basic_bcd got=%h exp=%h", frm.frame_bcd, e.bcd);
      end
      checks++;
      if (frm.frame_err !== e.err) begin
        failures++; $display("FAIL basic_err got=%b exp=%b", frm.frame_err, e.err);
      end
    end
    hold(dig_en, seg, 4);
    accept();
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL basic_valid_drop got=%b exp=0", frm.frame_valid);
    end
  endtask

  task automatic test_short_dwell();
    exp_t e;
    bit   ok;
    hold(4'b0000, 7'h00, 4);
    exp_q.push_back({16'h7265, 1'b0});
    show(0, 5, 8);
    show(1, 6, 8);
    show(3, 7, 8);
    show(2, 9, 2);
    hold(4'b0000, 7'h00, 6);
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL dwell_short_captured got=%b exp=0", frm.frame_valid);
    end
    show(2, 2, 3);
    hold(4'b0000, 7'h00, 1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL dwell_timeout got=valid0 exp=valid1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({frm.frame_bcd, frm.frame_err} !== {e.bcd, e.err}) begin
        failures++; $display("FAIL dwell_frame got=%h/%b exp=%h/%b", frm.frame_bcd, frm.frame_err, e.bcd, e.err);
      end
    end
    accept();
  endtask

  task automatic test_bad_pattern();
    exp_t e;
    bit   ok;
    exp_q.push_back({16'h08F1, 1'b1});
    show(0, 1, 8);
    hold(4'b0010, 7'h49, 8);
    show(2, 8, 8);
    show(3, 0, 8);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bad_timeout got=valid0 exp=valid1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({frm.frame_bcd, frm.frame_err} !== {e.bcd, e.err}) begin
        failures++; $display("FAIL bad_frame got=%h/%b exp=%h/%b", frm.frame_bcd, frm.frame_err, e.bcd, e.err);
      end
    end
    accept();
    // The error flag must not leak into the following clean frame.
    exp_q.push_back({16'h9999, 1'b0});
    scan(9, 9, 9, 9);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL clean_timeout got=valid0 exp=valid1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({frm.frame_bcd, frm.frame_err} !== {e.bcd, e.err}) begin
        failures++; $display("FAIL clean_frame got=%h/%b exp=%h/%b", frm.frame_bcd, frm.frame_err, e.bcd, e.err);
      end
    end
    accept();
  endtask

  task automatic test_overrun();
    exp_t e;
    bit   ok;
    ov_cnt = 0;
    exp_q.push_back({16'h4321, 1'b0});
    scan(1, 2, 3, 4);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL ovr_timeout got=valid0 exp=valid1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (frm.frame_bcd !== e.bcd) begin
        failures++; $display("FAIL ovr_first_bcd got=%h exp=%h", frm.frame_bcd, e.bcd);
      end
    end
    scan(5, 5, 5, 5);
    hold(4'b0000, 7'h00, 4);
    checks++;
    if (ov_cnt != 1) begin
      failures++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt);
    end
    checks++;
    if ({frm.frame_valid, frm.frame_bcd} !== {1'b1, 16'h4321}) begin
      failures++; $display("FAIL ovr_held got=%b/%h exp=1/4321", frm.frame_valid, frm.frame_bcd);
    end
    accept();
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL ovr_valid_drop got=%b exp=0", frm.frame_valid);
    end
  endtask

  task automatic test_onehot();
    exp_t e;
    bit   ok;
    show(0, 2, 8);
    hold(4'b0000, 7'h00, 3);
    oh_cnt = 0;
    hold(4'b0110, seg_tab[8], 5);
    hold(4'b0000, 7'h00, 3);
    checks++;
    if (oh_cnt != 1) begin
      failures++; $display("FAIL onehot_pulses got=%0d exp=1", oh_cnt);
    end
    show(3, 4, 8);
    hold(4'b0000, 7'h00, 4);
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL onehot_captured got=%b exp=0", frm.frame_valid);
    end
    exp_q.push_back({16'h4732, 1'b0});
    show(1, 3, 8);
    hold(4'b0000, 7'h00, 3);
    show(2, 7, 8);
    hold(4'b0000, 7'h00, 2);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL onehot_timeout got=valid0 exp=valid1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({frm.frame_bcd, frm.frame_err} !== {e.bcd, e.err}) begin
        failures++; $display("FAIL onehot_frame got=%h/%b exp=%h/%b", frm.frame_bcd, frm.frame_err, e.bcd, e.err);
      end
    end
    accept();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    show(2, 1, 8);
    show(3, 1, 8);
    rst_n = 1'b0;
    hold(4'b0000, 7'h00, 2);
    rst_n = 1'b1;
    hold(4'b0000, 7'h00, 2);
    show(0, 6, 8);
    show(1, 7, 8);
    hold(4'b0000, 7'h00, 3);
    checks++;
    if (frm.frame_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_stale_seen got=%b exp=0", frm.frame_valid);
    end
    exp_q.push_back({16'h9876, 1'b0});
    show(2, 8, 8);
    show(3, 9, 8);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rstmid_timeout got=valid0 exp=valid1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({frm.frame_bcd, frm.frame_err} !== {e.bcd, e.err}) begin
        failures++; $display("FAIL rstmid_frame got=%h/%b exp=%h/%b", frm.frame_bcd, frm.frame_err, e.bcd, e.err);
      end
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_dwell();
    test_bad_pattern();
    test_overrun();
    test_onehot();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
